// File: rtl/dcache_tag_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_tag_ctrl_if
// Brief    : Lookup, fill and tag-RAM bus bundle for dcache_tag_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_tag_ctrl_if #(
    parameter int NUM_SETS   = 2048,
    parameter int ADDR_WIDTH = $clog2(NUM_SETS),
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);
    logic                  lkup_req;
    logic [ADDR_WIDTH-1:0] lkup_addr;
    logic                  lkup_gnt;
    logic                  lkup_rvalid;
    logic [DATA_WIDTH-1:0] lkup_rdata;

    logic                  fill_req;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [NUM_COL-1:0]    fill_be;
    logic [DATA_WIDTH-1:0] fill_wdata;
    logic                  fill_gnt;

    logic                  ram_req;
    logic [NUM_COL-1:0]    ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Requesters and the tag RAM sit on the master side.
    modport master (
        output lkup_req, lkup_addr,
        input  lkup_gnt, lkup_rvalid, lkup_rdata,
        output fill_req, fill_addr, fill_be, fill_wdata,
        input  fill_gnt,
        input  ram_req, ram_wr_en, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  lkup_req, lkup_addr,
        output lkup_gnt, lkup_rvalid, lkup_rdata,
        input  fill_req, fill_addr, fill_be, fill_wdata,
        output fill_gnt,
        output ram_req, ram_wr_en, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_tag_ctrl
// Brief    : Tag RAM sequencer: invalidate sweep after reset/flush, then
//            fill-priority arbitration between fill writes and lookups.
//            Optional macro DCACHE_TAG_PERF_EN enables the lookup stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_tag_ctrl #(
    parameter int NUM_SETS   = 2048,
    parameter int ADDR_WIDTH = $clog2(NUM_SETS),
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    output logic        busy,
    output logic [31:0] stall_cnt,
    dcache_tag_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_LAST_IDX = ADDR_WIDTH'(NUM_SETS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_sweep_idx;
    logic [ADDR_WIDTH-1:0] w_sweep_idx_nxt;
    logic                  r_flush_pend;
    logic                  w_flush_pend_nxt;
    logic                  r_lkup_rvalid;
    logic                  w_lkup_gnt;
    logic                  w_fill_gnt;
    logic                  w_pend_any;

    // A flush arriving on the final sweep cycle still earns another sweep.
    assign w_pend_any = r_flush_pend | flush_req;

    always_comb begin
        w_state_nxt      = r_state;
        w_sweep_idx_nxt  = r_sweep_idx;
        w_flush_pend_nxt = r_flush_pend;
        busy             = 1'b1;
        w_fill_gnt       = 1'b0;
        w_lkup_gnt       = 1'b0;
        bus.ram_req      = 1'b0;
        bus.ram_wr_en    = '0;
        bus.ram_addr     = r_sweep_idx;
        bus.ram_wdata    = INIT_VAL;
        if (!rst) begin
            case (r_state)
                ST_SWEEP: begin
                    bus.ram_req      = 1'b1;
                    bus.ram_wr_en    = '1;
                    w_flush_pend_nxt = w_pend_any;
                    if (r_sweep_idx == C_LAST_IDX) begin
                        w_sweep_idx_nxt  = '0;
                        w_flush_pend_nxt = 1'b0;
                        w_state_nxt      = w_pend_any ? ST_SWEEP : ST_RUN;
                    end else begin
                        w_sweep_idx_nxt = r_sweep_idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    busy = 1'b0;
                    if (bus.fill_req) begin
                        w_fill_gnt    = 1'b1;
                        bus.ram_wr_en = bus.fill_be;
                        bus.ram_addr  = bus.fill_addr;
                        bus.ram_wdata = bus.fill_wdata;
                    end else if (bus.lkup_req) begin
                        w_lkup_gnt    = 1'b1;
                        bus.ram_addr  = bus.lkup_addr;
                    end
                    bus.ram_req = w_fill_gnt | w_lkup_gnt;
                    if (flush_req) begin
                        w_state_nxt     = ST_SWEEP;
                        w_sweep_idx_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt     = ST_SWEEP;
                    w_sweep_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SWEEP;
            r_sweep_idx   <= '0;
            r_flush_pend  <= 1'b0;
            r_lkup_rvalid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sweep_idx   <= w_sweep_idx_nxt;
            r_flush_pend  <= w_flush_pend_nxt;
            r_lkup_rvalid <= w_lkup_gnt;
        end
    end

    assign bus.fill_gnt    = w_fill_gnt;
    assign bus.lkup_gnt    = w_lkup_gnt;
    assign bus.lkup_rvalid = r_lkup_rvalid & ~rst;
    assign bus.lkup_rdata  = bus.ram_rdata;

`ifdef DCACHE_TAG_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.lkup_req && !w_lkup_gnt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = rst ? 32'h0 : r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
